four_bit_cpu_bootloader: RTL and testbench

Program loader sitting directly upstream of the 4-bit CPU's bootloader port. Receives program nibbles from external pins via a strobe handshake, synchronises them into the clock domain, and writes them sequentially into CPU instruction memory. It drives the CPU's programming request, data, address and write-enable inputs, and holds the CPU in programming mode while a load is in progress.

---
 rtl/four_bit_cpu_bootloader.sv | 152 +++++++++++++++
 tb/tb_four_bit_cpu_bootloader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/four_bit_cpu_bootloader.sv
// Program loader for the 4-bit CPU: synchronises externally strobed nibbles and writes them
// sequentially into instruction memory. Optional checksum stage enabled by BOOTLOADER_CHECKSUM_EN.
module four_bit_cpu_bootloader #(
  parameter int REGISTER_WIDTH       = 4,
  parameter int MEMORY_ADDRESS_WIDTH = 4,
  parameter int MEMORY_REGISTERS     = 16
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            prog_en_i,
  input  logic                            strobe_i,
  input  logic [REGISTER_WIDTH-1:0]       nibble_i,
  output logic                            bl_programm_o,
  output logic [REGISTER_WIDTH-1:0]       bl_data_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] bl_address_o,
  output logic                            bl_write_en_mem_o,
  output logic                            done_o,
  output logic                            error_o
);

  localparam logic [MEMORY_ADDRESS_WIDTH-1:0] LAST_ADDR =
    MEMORY_ADDRESS_WIDTH'(MEMORY_REGISTERS - 1);

`ifdef BOOTLOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;
  logic [REGISTER_WIDTH-1:0] acc;
  logic                      error_q;
  assign error_o = error_q;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  assign error_o = 1'b0;
`endif

  state_t                    state;
  logic [1:0]                prog_sync;
  logic [2:0]                strb_sync;
  logic [REGISTER_WIDTH-1:0] nib_sync1, nib_sync2;
  logic                      prog_en_s, strb_rise;

  assign prog_en_s = prog_sync[1];
  assign strb_rise = strb_sync[1] & ~strb_sync[2];

  // NOTE: every register here is updated with <= so all flops see pre-edge values;
  // blocking assignments in a clocked block would create order-dependent shift chains.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state             <= IDLE;
      prog_sync         <= '0;
      strb_sync         <= '0;
      nib_sync1         <= '0;
      nib_sync2         <= '0;
      bl_programm_o     <= 1'b0;
      bl_data_o         <= '0;
      bl_address_o      <= '0;
      bl_write_en_mem_o <= 1'b0;
      done_o            <= 1'b0;
`ifdef BOOTLOADER_CHECKSUM_EN
      acc               <= '0;
      error_q           <= 1'b0;
`endif
    end else begin
      prog_sync         <= {prog_sync[0], prog_en_i};
      strb_sync         <= {strb_sync[1:0], strobe_i};
      nib_sync1         <= nibble_i;
      nib_sync2         <= nib_sync1;
      bl_write_en_mem_o <= 1'b0;

      case (state)
        IDLE: begin
          bl_programm_o <= 1'b0;
          if (prog_en_s) begin
            state         <= LOAD;
            bl_programm_o <= 1'b1;
            bl_address_o  <= '0;
            done_o        <= 1'b0;
`ifdef BOOTLOADER_CHECKSUM_EN
            acc           <= '0;
            error_q       <= 1'b0;
`endif
          end
        end

        LOAD: begin
          if (!prog_en_s) begin
            // Abort: words already written stay in memory, flags cleared.
            state         <= IDLE;
            bl_programm_o <= 1'b0;
            done_o        <= 1'b0;
`ifdef BOOTLOADER_CHECKSUM_EN
            error_q       <= 1'b0;
`endif
          end else if (bl_write_en_mem_o) begin
            // Edge ending the write pulse: advance address, leave after the last word.
            if (bl_address_o == LAST_ADDR) begin
              bl_address_o <= '0;
`ifdef BOOTLOADER_CHECKSUM_EN
              state        <= CHECK;
`else
              state         <= DONE;
              done_o        <= 1'b1;
              bl_programm_o <= 1'b0;
`endif
            end else begin
              bl_address_o <= bl_address_o + MEMORY_ADDRESS_WIDTH'(1);
            end
          end else if (strb_rise) begin
            bl_data_o         <= nib_sync2;
            bl_write_en_mem_o <= 1'b1;
`ifdef BOOTLOADER_CHECKSUM_EN
            acc               <= acc + nib_sync2;
`endif
          end
        end

`ifdef BOOTLOADER_CHECKSUM_EN
        CHECK: begin
          if (!prog_en_s) begin
            state         <= IDLE;
            bl_programm_o <= 1'b0;
            done_o        <= 1'b0;
            error_q       <= 1'b0;
          end else if (strb_rise) begin
            if (nib_sync2 == acc) begin
              state         <= DONE;
              done_o        <= 1'b1;
              bl_programm_o <= 1'b0;
            end else begin
              // CPU stays held in programming mode until the host drops prog_en.
              state   <= ERROR;
              error_q <= 1'b1;
            end
          end
        end

        ERROR: begin
          if (!prog_en_s) begin
            state         <= IDLE;
            bl_programm_o <= 1'b0;
          end
        end
`endif

        DONE: begin
          if (!prog_en_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_four_bit_cpu_bootloader.sv
// Scoreboard bench for four_bit_cpu_bootloader: expected (address, data) writes are queued by the
// stimulus and popped by a monitor on every write pulse; status outputs checked directly.
module tb_four_bit_cpu_bootloader;

  typedef struct packed {
    logic [3:0] addr;
    logic [3:0] data;
  } wr_t;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       prog_en_i;
  logic       strobe_i;
  logic [3:0] nibble_i;
  logic       bl_programm_o;
  logic [3:0] bl_data_o;
  logic [3:0] bl_address_o;
  logic       bl_write_en_mem_o;
  logic       done_o;
  logic       error_o;

  int  n_checks = 0;
  int  n_fails  = 0;
  int  n_writes = 0;
  wr_t exp_q[$];
  logic prev_we = 1'b0;

  four_bit_cpu_bootloader dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .prog_en_i         (prog_en_i),
    .strobe_i          (strobe_i),
    .nibble_i          (nibble_i),
    .bl_programm_o     (bl_programm_o),
    .bl_data_o         (bl_data_o),
    .bl_address_o      (bl_address_o),
    .bl_write_en_mem_o (bl_write_en_mem_o),
    .done_o            (done_o),
    .error_o           (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every write pulse must match the head of the expected queue and last one cycle.
  always @(negedge clk_i) begin
    if (!reset_i && bl_write_en_mem_o) begin
      n_writes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write (t=%0t)",
                 bl_address_o, bl_data_o, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bl_address_o !== e.addr || bl_data_o !== e.data) begin
          n_fails++;
          $display("FAIL write: addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h (t=%0t)",
                   bl_address_o, bl_data_o, e.addr, e.data, $time);
        end
      end
      if (prev_we) begin
        n_checks++;
        n_fails++;
        $display("FAIL pulse_width: write enable high 2+ cycles, expected 1 (t=%0t)", $time);
      end
    end
    prev_we = bl_write_en_mem_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic strobe_nibble(input logic [3:0] n);
    nibble_i = n;
    cycles(2);
    strobe_i = 1'b1;
    cycles(4);
    strobe_i = 1'b0;
    cycles(4);
  endtask

  task automatic load_expect(input logic [3:0] a, input logic [3:0] n);
    exp_q.push_back('{addr: a, data: n});
    strobe_nibble(n);
  endtask

  task automatic set_prog(input logic v);
    prog_en_i = v;
    cycles(3);
  endtask

  initial begin
    int w0;
    reset_i = 1'b1; prog_en_i = 1'b0; strobe_i = 1'b0; nibble_i = 4'h0;
    cycles(3);
    check("reset_programm", {7'd0, bl_programm_o}, 8'd0);
    check("reset_we",       {7'd0, bl_write_en_mem_o}, 8'd0);
    check("reset_data",     {4'd0, bl_data_o}, 8'd0);
    check("reset_addr",     {4'd0, bl_address_o}, 8'd0);
    check("reset_done",     {7'd0, done_o}, 8'd0);
    check("reset_error",    {7'd0, error_o}, 8'd0);
    reset_i = 1'b0;
    cycles(2);

    // prog_en first sampled at edge k -> programming mode after edge k+2.
    prog_en_i = 1'b1;
    cycles(2);
    check("prog_latency_k1", {7'd0, bl_programm_o}, 8'd0);
    cycles(1);
    check("prog_latency_k2", {7'd0, bl_programm_o}, 8'd1);

    for (int i = 0; i < 16; i++) load_expect(4'(i), 4'(i));
    check("full_done",     {7'd0, done_o}, 8'd1);
    check("full_programm", {7'd0, bl_programm_o}, 8'd0);
    check("full_addr",     {4'd0, bl_address_o}, 8'd0);
    check("full_writes",   8'(n_writes), 8'd16);
    check("full_error",    {7'd0, error_o}, 8'd0);

    // Strobes in DONE and then IDLE must not write.
    strobe_nibble(4'h7);
    strobe_nibble(4'h8);
    set_prog(1'b0);
    check("idle_done_sticky", {7'd0, done_o}, 8'd1);
    strobe_nibble(4'h9);
    check("ignored_writes", 8'(n_writes), 8'd16);
    check("ignored_addr",   {4'd0, bl_address_o}, 8'd0);

    // New load; one strobe held high 10 cycles with pulse timing checked.
    set_prog(1'b1);
    check("reload_done", {7'd0, done_o}, 8'd0);
    check("reload_prog", {7'd0, bl_programm_o}, 8'd1);
    exp_q.push_back('{addr: 4'h0, data: 4'hA});
    nibble_i = 4'hA;
    cycles(2);
    strobe_i = 1'b1;
    cycles(1);   // after edge k
    cycles(1);   // after edge k+1
    check("held_we_k1", {7'd0, bl_write_en_mem_o}, 8'd0);
    cycles(1);   // after edge k+2
    check("held_we_k2", {7'd0, bl_write_en_mem_o}, 8'd1);
    cycles(1);   // after edge k+3
    check("held_we_k3", {7'd0, bl_write_en_mem_o}, 8'd0);
    check("held_addr_k3", {4'd0, bl_address_o}, 8'd1);
    cycles(7);
    strobe_i = 1'b0;
    cycles(4);
    check("held_single_write", 8'(n_writes), 8'd17);

    for (int i = 1; i < 5; i++) load_expect(4'(i), 4'(i));
    set_prog(1'b0);
    check("abort_prog", {7'd0, bl_programm_o}, 8'd0);
    check("abort_done", {7'd0, done_o}, 8'd0);
    strobe_nibble(4'hC);
    check("abort_writes", 8'(n_writes), 8'd21);

    // Load restarts at 0, then an asynchronous reset after 8 writes.
    set_prog(1'b1);
    check("restart_addr", {4'd0, bl_address_o}, 8'd0);
    for (int i = 0; i < 8; i++) load_expect(4'(i), 4'(15 - i));
    #2;
    reset_i = 1'b1;
    #1;
    check("async_rst_programm", {7'd0, bl_programm_o}, 8'd0);
    check("async_rst_addr",     {4'd0, bl_address_o}, 8'd0);
    check("async_rst_data",     {4'd0, bl_data_o}, 8'd0);
    cycles(2);
    reset_i = 1'b0;
    cycles(3);
    check("post_rst_prog", {7'd0, bl_programm_o}, 8'd1);
    load_expect(4'h0, 4'h5);
    load_expect(4'h1, 4'h6);
    set_prog(1'b0);

`ifdef BOOTLOADER_CHECKSUM_EN
    set_prog(1'b1);
    for (int i = 0; i < 16; i++) load_expect(4'(i), 4'h1);
    strobe_nibble(4'h0);
    check("cks_ok_done",  {7'd0, done_o}, 8'd1);
    check("cks_ok_error", {7'd0, error_o}, 8'd0);
    check("cks_ok_prog",  {7'd0, bl_programm_o}, 8'd0);
    set_prog(1'b0);
    set_prog(1'b1);
    w0 = n_writes;
    for (int i = 0; i < 16; i++) load_expect(4'(i), 4'h1);
    strobe_nibble(4'h1);
    check("cks_bad_error",  {7'd0, error_o}, 8'd1);
    check("cks_bad_done",   {7'd0, done_o}, 8'd0);
    check("cks_bad_prog",   {7'd0, bl_programm_o}, 8'd1);
    check("cks_bad_writes", 8'(n_writes - w0), 8'd16);
    set_prog(1'b0);
    check("cks_err_idle_prog",  {7'd0, bl_programm_o}, 8'd0);
    check("cks_err_sticky",     {7'd0, error_o}, 8'd1);
`else
    w0 = n_writes;
    check("total_writes", 8'(w0), 8'd31);
`endif

    cycles(4);
    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
